// File: rtl/vga_reg_panel.sv
// rtl/vga_reg_panel.sv - register bit-cell overlay on a 1-bit background with per-row change highlight
// Optional freeze input (snapshot hold) enabled by defining VGA_REG_PANEL_FREEZE_EN.
module vga_reg_panel #(
    parameter int          NUM_REGS      = 7,
    parameter int          DATA_WIDTH    = 8,
    parameter int          H_ACTIVE      = 800,
    parameter int          V_ACTIVE      = 480,
    parameter int          START_H       = 50,
    parameter int          START_V       = 10,
    parameter int          ROW_PITCH     = 30,
    parameter int          BIT_PITCH     = 24,
    parameter int          CELL_W        = 20,
    parameter int          CELL_H        = 20,
    parameter int          HOLD_FRAMES   = 30,
    parameter logic [23:0] ON_COLOUR     = 24'h00FF00,
    parameter logic [23:0] OFF_COLOUR    = 24'h003000,
    parameter logic [23:0] HL_ON_COLOUR  = 24'hFFFF00,
    parameter logic [23:0] HL_OFF_COLOUR = 24'h404000
) (
    input  logic                           clk,
    input  logic                           reset,
`ifdef VGA_REG_PANEL_FREEZE_EN
    input  logic                           freeze,
`endif
    input  logic [NUM_REGS*DATA_WIDTH-1:0] regs_in,
    input  logic [10:0]                    vga_h,
    input  logic [10:0]                    vga_v,
    input  logic                           bg_bit,
    output logic [23:0]                    pixel_out,
    output logic                           frame_tick
);
    localparam int            HW        = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_FRAMES);

    logic [DATA_WIDTH-1:0] snap [NUM_REGS];
    logic [HW-1:0]         hold [NUM_REGS];
    logic                  first_snap;

    logic [31:0] h32;
    logic [31:0] v32;
    logic        snap_event;
    logic        capture;

    assign h32        = {21'd0, vga_h};
    assign v32        = {21'd0, vga_v};
    assign snap_event = (vga_h == 11'd0) && (vga_v == 11'(V_ACTIVE));

`ifdef VGA_REG_PANEL_FREEZE_EN
    // A frozen event still ticks but leaves snapshot and hold counters untouched.
    assign capture = snap_event && !freeze;
`else
    assign capture = snap_event;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            first_snap <= 1'b0;
            frame_tick <= 1'b0;
            for (int r = 0; r < NUM_REGS; r++) begin
                snap[r] <= '0;
                hold[r] <= '0;
            end
        end else begin
            frame_tick <= snap_event;
            if (capture) begin
                first_snap <= 1'b1;
                for (int r = 0; r < NUM_REGS; r++) begin
                    snap[r] <= regs_in[r*DATA_WIDTH +: DATA_WIDTH];
                    if (first_snap && (regs_in[r*DATA_WIDTH +: DATA_WIDTH] != snap[r])) begin
                        hold[r] <= HOLD_LOAD;
                    end else if (hold[r] != '0) begin
                        hold[r] <= hold[r] - HW'(1);
                    end
                end
            end
        end
    end

    logic                  in_active;
    logic                  row_hit;
    logic                  row_hl;
    logic [DATA_WIDTH-1:0] row_data;
    logic                  cell_hit;
    logic                  cell_bit;

    assign in_active = (h32 < 32'(H_ACTIVE)) && (v32 < 32'(V_ACTIVE));

    // Rows and cells never overlap (CELL_H <= ROW_PITCH, CELL_W <= BIT_PITCH), so at most one compare fires.
    always_comb begin
        row_hit  = 1'b0;
        row_hl   = 1'b0;
        row_data = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if ((v32 >= 32'(START_V + r*ROW_PITCH)) &&
                (v32 <  32'(START_V + r*ROW_PITCH + CELL_H))) begin
                row_hit  = 1'b1;
                row_hl   = (hold[r] != '0);
                row_data = snap[r];
            end
        end
        cell_hit = 1'b0;
        cell_bit = 1'b0;
        for (int k = 0; k < DATA_WIDTH; k++) begin
            if ((h32 >= 32'(START_H + k*BIT_PITCH)) &&
                (h32 <  32'(START_H + k*BIT_PITCH + CELL_W))) begin
                cell_hit = 1'b1;
                cell_bit = row_data[DATA_WIDTH-1-k];
            end
        end
    end

    logic s1_active;
    logic s1_hit;
    logic s1_bit;
    logic s1_hl;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_active <= 1'b0;
            s1_hit    <= 1'b0;
            s1_bit    <= 1'b0;
            s1_hl     <= 1'b0;
        end else begin
            s1_active <= in_active;
            s1_hit    <= row_hit && cell_hit;
            s1_bit    <= cell_bit;
            s1_hl     <= row_hl;
        end
    end

    // bg_bit lags its coordinates by one clk, so it lines up with the stage-1 registers here.
    always_ff @(posedge clk) begin
        if (reset) begin
            pixel_out <= 24'h000000;
        end else if (!s1_active) begin
            pixel_out <= 24'h000000;
        end else if (s1_hit && s1_hl) begin
            pixel_out <= s1_bit ? HL_ON_COLOUR : HL_OFF_COLOUR;
        end else if (s1_hit) begin
            pixel_out <= s1_bit ? ON_COLOUR : OFF_COLOUR;
        end else begin
            pixel_out <= {24{bg_bit}};
        end
    end

endmodule

// File: tb/tb_vga_reg_panel.sv
// tb/tb_vga_reg_panel.sv - directed checks of vga_reg_panel (default and HOLD_FRAMES=0 instances)
module tb_vga_reg_panel;
    localparam logic [23:0] C_ON     = 24'h00FF00;
    localparam logic [23:0] C_OFF    = 24'h003000;
    localparam logic [23:0] C_HL_ON  = 24'hFFFF00;
    localparam logic [23:0] C_HL_OFF = 24'h404000;
    localparam logic [23:0] C_BLACK  = 24'h000000;
    localparam logic [23:0] C_WHITE  = 24'hFFFFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic [55:0] regs_in;
    logic [10:0] vga_h;
    logic [10:0] vga_v;
    logic        bg_bit;
    logic [23:0] pixel_out;
    logic [23:0] pixel_out0;
    logic        frame_tick;
    logic        frame_tick0;
    logic [23:0] last_p;
    logic [23:0] last_p0;
    logic [7:0]  r3_val;
    int          total = 0;
    int          bad   = 0;
`ifdef VGA_REG_PANEL_FREEZE_EN
    logic        freeze = 1'b0;
`endif

    always #5 clk = ~clk;

    vga_reg_panel dut (
        .clk        (clk),
        .reset      (reset),
`ifdef VGA_REG_PANEL_FREEZE_EN
        .freeze     (freeze),
`endif
        .regs_in    (regs_in),
        .vga_h      (vga_h),
        .vga_v      (vga_v),
        .bg_bit     (bg_bit),
        .pixel_out  (pixel_out),
        .frame_tick (frame_tick)
    );

    vga_reg_panel #(.HOLD_FRAMES(0)) dut0 (
        .clk        (clk),
        .reset      (reset),
`ifdef VGA_REG_PANEL_FREEZE_EN
        .freeze     (freeze),
`endif
        .regs_in    (regs_in),
        .vga_h      (vga_h),
        .vga_v      (vga_v),
        .bg_bit     (bg_bit),
        .pixel_out  (pixel_out0),
        .frame_tick (frame_tick0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic probe(input int h, input int v, input logic bg);
        @(negedge clk);
        vga_h = 11'(h);
        vga_v = 11'(v);
        @(negedge clk);
        bg_bit = bg;
        vga_h  = 11'd900;
        vga_v  = 11'd900;
        @(negedge clk);
        last_p  = pixel_out;
        last_p0 = pixel_out0;
    endtask

    task automatic pix(input string tag, input int h, input int v, input logic bg, input logic [23:0] exp);
        probe(h, v, bg);
        check(tag, {8'd0, last_p}, {8'd0, exp});
    endtask

    task automatic do_snap();
        @(negedge clk);
        vga_h = 11'd0;
        vga_v = 11'd480;
        @(negedge clk);
        check("tick", {31'd0, frame_tick}, 32'd1);
        check("tick0", {31'd0, frame_tick0}, 32'd1);
        vga_h = 11'd900;
        vga_v = 11'd900;
        @(negedge clk);
        check("tick_low", {31'd0, frame_tick}, 32'd0);
    endtask

    // Called right after the change snapshot: 29 more highlighted frames, then normal.
    task automatic hl_run(input string tag, input int h, input int v, input logic b);
        for (int i = 1; i < 30; i++) begin
            do_snap();
            pix(tag, h, v, 1'b0, b ? C_HL_ON : C_HL_OFF);
        end
        do_snap();
        pix({tag, "_end"}, h, v, 1'b0, b ? C_ON : C_OFF);
    endtask

    initial begin
        reset   = 1'b1;
        vga_h   = 11'd900;
        vga_v   = 11'd900;
        bg_bit  = 1'b0;
        for (int r = 0; r < 7; r++) regs_in[r*8 +: 8] = 8'hA5;
        regs_in[16 +: 8] = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_pix", {8'd0, pixel_out}, 32'd0);
        check("rst_tick", {31'd0, frame_tick}, 32'd0);
        reset = 1'b0;

        pix("pre_snap", 50, 10, 1'b1, C_OFF);

        // First snapshot: non-zero regs, no highlight.
        do_snap();
        r3_val = 8'hA5;
        for (int k = 0; k < 8; k++) begin
            pix("row0", 50 + 24*k, 10, 1'b0, r3_val[7-k] ? C_ON : C_OFF);
        end
        pix("bg_left", 45, 10, 1'b1, C_WHITE);
        pix("h_clip", 800, 10, 1'b1, C_BLACK);
        pix("cell_gap1", 70, 10, 1'b1, C_WHITE);
        pix("cell_gap0", 70, 10, 1'b0, C_BLACK);
        pix("row_gap", 50, 30, 1'b1, C_WHITE);
        pix("last_cell", 218, 190, 1'b1, C_ON);
        pix("cell8", 242, 10, 1'b1, C_WHITE);
        pix("row7", 50, 220, 1'b1, C_WHITE);
        pix("v_clip", 50, 480, 1'b1, C_BLACK);

        // Reg 2 change mid-frame is not shown until the next snapshot.
        regs_in[16 +: 8] = 8'h01;
        pix("r2_before", 218, 70, 1'b0, C_OFF);
        do_snap();
        pix("r2_hl", 218, 70, 1'b0, C_HL_ON);
        check("r2_hold0", {8'd0, last_p0}, {8'd0, C_ON});
        pix("r2_cell0", 50, 70, 1'b0, C_HL_OFF);
        pix("r0_plain", 50, 10, 1'b0, C_ON);
        hl_run("r2_run", 218, 70, 1'b1);

        // Reg 3 changing every 10 frames keeps its row lit.
        for (int c = 0; c < 4; c++) begin
            r3_val = ~r3_val;
            regs_in[24 +: 8] = r3_val;
            for (int f = 0; f < 10; f++) begin
                do_snap();
                pix("r3_cont", 50, 100, 1'b0, r3_val[7] ? C_HL_ON : C_HL_OFF);
            end
        end
        check("r3_hold0", {8'd0, last_p0}, {8'd0, r3_val[7] ? C_ON : C_OFF});
        r3_val = ~r3_val;
        regs_in[24 +: 8] = r3_val;
        do_snap();
        pix("r3_last", 50, 100, 1'b0, r3_val[7] ? C_HL_ON : C_HL_OFF);
        hl_run("r3_run", 50, 100, r3_val[7]);

        // Mid-frame reset with a changed register pending.
        regs_in[8 +: 8] = 8'h3C;
        @(negedge clk);
        vga_h = 11'd50;
        vga_v = 11'd10;
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst", {8'd0, pixel_out}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        vga_h = 11'd900;
        vga_v = 11'd900;
        pix("post_rst", 50, 10, 1'b0, C_OFF);
        do_snap();
        pix("first_r1", 50, 40, 1'b0, C_OFF);
        pix("first_r2", 218, 70, 1'b0, C_ON);

`ifdef VGA_REG_PANEL_FREEZE_EN
        freeze = 1'b1;
        regs_in[8 +: 8] = 8'hC3;
        for (int f = 0; f < 3; f++) begin
            do_snap();
            pix("frozen", 50, 40, 1'b0, C_OFF);
        end
        freeze = 1'b0;
        do_snap();
        pix("unfrozen", 50, 40, 1'b0, C_HL_ON);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
